// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared op-code constants, FSM encoding and op-class helpers
//                for the multiply/divide unit.
//  Revision    : 1.0
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL    = 3'd1,
        ST_DIV    = 3'd2,
        ST_FIX    = 3'd3,
        ST_MOVE   = 3'd4,
        ST_COMMIT = 3'd5
    } mdu_state_e;

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Combinational restoring-division step producing DIV_BITS_CYC
//                quotient bits on unsigned (absolute) operands.
//  Revision    : 1.0
// ============================================================================
module div_iter
    import mdu_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DIV_BITS_CYC = 1
) (
    input  logic [DATA_WD-1:0] i_rem,
    input  logic [DATA_WD-1:0] i_quo,
    input  logic [DATA_WD-1:0] i_divisor,
    output logic [DATA_WD-1:0] o_rem,
    output logic [DATA_WD-1:0] o_quo
);

    logic [DATA_WD:0]   v_trial;
    logic [DATA_WD-1:0] v_rem;
    logic [DATA_WD-1:0] v_quo;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while new quotient bits enter at the LSB.
    always_comb begin
        v_rem   = i_rem;
        v_quo   = i_quo;
        v_trial = '0;
        for (int i = 0; i < DIV_BITS_CYC; i++) begin
            v_trial = {v_rem, v_quo[DATA_WD-1]};
            v_quo   = {v_quo[DATA_WD-2:0], 1'b0};
            if (v_trial >= {1'b0, i_divisor}) begin
                v_trial  = v_trial - {1'b0, i_divisor};
                v_quo[0] = 1'b1;
            end
            v_rem = v_trial[DATA_WD-1:0];
        end
        o_rem = v_rem;
        o_quo = v_quo;
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_div_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO,
//                with flush cancel and configurable multiply/divide latency.
//  Revision    : 1.0
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int MUL_STAGES   = 2,
    parameter int DIV_BITS_CYC = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [2:0]         op_code,
    input  logic [DATA_WD-1:0] op_src1,
    input  logic [DATA_WD-1:0] op_src2,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [DATA_WD-1:0] hi_rdata,
    output logic [DATA_WD-1:0] lo_rdata
);

    localparam int c_DIV_ITERS = DATA_WD / DIV_BITS_CYC;
    localparam int c_CNT_WD    = $clog2(c_DIV_ITERS + MUL_STAGES + 1);

    mdu_state_e r_state, w_state_nx;

    logic [2:0]           r_op;
    logic [DATA_WD-1:0]   r_a, r_b;
    logic [DATA_WD-1:0]   r_rem, r_quo, r_dvs;
    logic                 r_q_neg, r_r_neg, r_dvs_zero;
    logic [c_CNT_WD-1:0]  r_cnt;
    logic [DATA_WD-1:0]   r_hi, r_lo;
    logic                 r_done;
    logic [2*DATA_WD-1:0] r_mul_pipe [MUL_STAGES];

    logic                 w_accept, w_div_signed, w_s1_neg, w_s2_neg, w_mul_signed;
    logic [DATA_WD-1:0]   w_abs1, w_abs2, w_rem_nx, w_quo_nx;
    logic [2*DATA_WD-1:0] w_a_ext, w_b_ext, w_product;

    assign op_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept = op_valid && op_ready && !flush;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign hi_rdata = r_hi;
    assign lo_rdata = r_lo;

    assign w_div_signed = (op_code == MDU_DIV);
    assign w_s1_neg     = w_div_signed & op_src1[DATA_WD-1];
    assign w_s2_neg     = w_div_signed & op_src2[DATA_WD-1];
    assign w_abs1       = w_s1_neg ? (~op_src1 + 1'b1) : op_src1;
    assign w_abs2       = w_s2_neg ? (~op_src2 + 1'b1) : op_src2;

    // Sign-extending to the full product width makes a plain modular multiply
    // yield the correct signed or unsigned 2*DATA_WD result.
    assign w_mul_signed = (r_op == MDU_MULT);
    assign w_a_ext      = {{DATA_WD{w_mul_signed & r_a[DATA_WD-1]}}, r_a};
    assign w_b_ext      = {{DATA_WD{w_mul_signed & r_b[DATA_WD-1]}}, r_b};
    assign w_product    = w_a_ext * w_b_ext;

    div_iter #(
        .DATA_WD      (DATA_WD),
        .DIV_BITS_CYC (DIV_BITS_CYC)
    ) u_div_iter (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (op_is_mul(op_code))      w_state_nx = ST_MUL;
                    else if (op_is_div(op_code)) w_state_nx = ST_DIV;
                    else                         w_state_nx = ST_MOVE;
                end
            end
            ST_MUL:    if (r_cnt == '0) w_state_nx = ST_COMMIT;
            ST_DIV:    if (r_cnt == '0) w_state_nx = ST_FIX;
            ST_FIX,
            ST_MOVE:   w_state_nx = ST_COMMIT;
            ST_COMMIT: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
        if (flush && (r_state != ST_IDLE)) begin
            w_state_nx = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op       <= op_code;
            r_a        <= op_src1;
            r_b        <= op_src2;
            r_rem      <= '0;
            r_quo      <= w_abs1;
            r_dvs      <= w_abs2;
            r_dvs_zero <= (op_src2 == '0);
            r_q_neg    <= w_s1_neg ^ w_s2_neg;
            r_r_neg    <= w_s1_neg;
            r_cnt      <= op_is_mul(op_code) ? c_CNT_WD'(MUL_STAGES - 1)
                                             : c_CNT_WD'(c_DIV_ITERS - 1);
        end else if ((r_state == ST_MUL) || (r_state == ST_DIV)) begin
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            if (r_state == ST_DIV) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
            end
        end else if (r_state == ST_FIX) begin
            // Divide-by-zero returns all-ones / original dividend for both signednesses.
            if (r_dvs_zero) begin
                r_quo <= '1;
                r_rem <= r_a;
            end else begin
                if (r_q_neg) r_quo <= ~r_quo + 1'b1;
                if (r_r_neg) r_rem <= ~r_rem + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_mul_pipe[0] <= w_product;
        for (int i = 1; i < MUL_STAGES; i++) begin
            r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_COMMIT) && !flush;
            if ((r_state == ST_COMMIT) && !flush) begin
                case (r_op)
                    MDU_MULT,
                    MDU_MULTU: {r_hi, r_lo} <= r_mul_pipe[MUL_STAGES-1];
                    MDU_DIV,
                    MDU_DIVU: begin
                        r_hi <= r_rem;
                        r_lo <= r_quo;
                    end
                    MDU_MTHI:  r_hi <= r_a;
                    MDU_MTLO:  r_lo <= r_a;
                    default:   ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
